bin2bcd_conv: RTL
=================

BIN2BCD_CONV -- requirements
Module: bin2bcd_conv

Interface
REQ-001 SHALL have parameter data_size, default 8: width of the binary input.
REQ-002 SHALL have parameter digit_num, default 3: number of BCD digits produced.
REQ-003 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port load, input, 1 bit: conversion request, driven by the upstream multiplier's ready output (level signal).
REQ-006 SHALL have port in_data, input, data_size bits: binary value, driven by the upstream multiplier's result output.
REQ-007 SHALL have port ready, output, 1 bit: high when idle and bcd is valid.
REQ-008 SHALL have port bcd, output, 4*digit_num bits: packed BCD, digit 0 (units) in bits [3:0].
REQ-009 SHALL have port digit_en, output, digit_num bits: per-digit display enable for the seven-segment driver.

Function
REQ-010 SHALL register load into load_q and detect a request only on a rising edge (load=1, load_q=0); a constant-high load SHALL start one conversion only.
REQ-011 SHALL implement FSM states IDLE (ready=1) and CONV (ready=0).
REQ-012 IDLE->CONV on a detected request: capture in_data into the binary shift register, clear the working BCD register, and load the bit counter with data_size.
REQ-013 In each CONV cycle, SHALL first add 3 to every working digit >=5, then shift {working, binary} left by 1 and decrement the counter.
REQ-014 After exactly data_size CONV cycles (counter reaching 0), SHALL return to IDLE and copy the working register into bcd on that same edge.
REQ-015 Latency: for a request detected in cycle k, ready SHALL be low in cycles k+1..k+data_size, and the new bcd with ready=1 SHALL appear in cycle k+data_size+1.
REQ-016 bcd SHALL hold its previous value throughout CONV; bcd and digit_en SHALL change only on the IDLE-return edge.
REQ-017 Load edges arriving during CONV SHALL be ignored, not queued; load_q SHALL still track load, so a level that stays high across the return to IDLE does not retrigger.
REQ-018 If digit_num is too small for 2^data_size-1, bcd SHALL equal in_data mod 10^digit_num, with no error flag.
REQ-019 in_data SHALL be sampled only on the request edge; later changes SHALL not affect the conversion in progress.

Reset
REQ-020 On reset=1: state=IDLE, ready=1, bcd=0, load_q=0, counter=0, shift and working registers=0, digit_en per REQ-023/024 for value 0.
REQ-021 Reset mid-CONV SHALL abort immediately; the first request edge after reset release SHALL start a fresh conversion.
REQ-022 Because load_q resets to 0, an upstream ready that is high at reset release SHALL trigger one conversion.

Configuration
REQ-023 With macro LEADING_ZERO_BLANK_EN defined: digit_en[i]=0 for every zero digit above the most significant non-zero digit; digit_en[0] SHALL always be 1.
REQ-024 Without LEADING_ZERO_BLANK_EN: digit_en SHALL be all ones, and no blanking logic SHALL be synthesized.

Verification
REQ-025 in_data=8'd0, load 0->1 -> ready low 8 cycles, then bcd=12'h000, ready=1.
REQ-026 in_data=8'd255, load edge -> after 9 cycles bcd=12'h255; in_data changed to 8'd3 mid-conversion has no effect.
REQ-027 in_data=8'd105, load held high for 30 cycles -> exactly one conversion, bcd=12'h105, ready low exactly 8 cycles.
REQ-028 Reset asserted during the 4th CONV cycle of 8'd200 -> ready=1 and bcd=0 asynchronously; next load edge with 8'd200 -> bcd=12'h200.
REQ-029 With LEADING_ZERO_BLANK_EN: 8'd7 -> digit_en=3'b001; 8'd0 -> 3'b001; 8'd40 -> 3'b011. Without the macro -> 3'b111 in all three cases.
REQ-030 data_size=8, digit_num=2, in_data=8'd237 -> bcd=8'h37.

Source files
------------

// File: rtl/bin2bcd_conv.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bin2bcd_conv
// Brief    : Sequential double-dabble binary-to-BCD converter with edge-detected
//            request and optional leading-zero blanking (LEADING_ZERO_BLANK_EN).
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_conv #(
    parameter int data_size = 8,
    parameter int digit_num = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load,
    input  logic [data_size-1:0]   in_data,
    output logic                   ready,
    output logic [4*digit_num-1:0] bcd,
    output logic [digit_num-1:0]   digit_en
);

    localparam int c_CNT_W = $clog2(data_size + 1);
    localparam int c_BCD_W = 4 * digit_num;
    localparam int c_SHW   = c_BCD_W + data_size;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_load_q;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [data_size-1:0] r_bin;
    logic [c_BCD_W-1:0]   r_work;
    logic [c_BCD_W-1:0]   r_bcd;
    logic [c_BCD_W-1:0]   w_adj;
    logic [c_SHW-1:0]     w_shift;
    logic                 w_req;
    logic                 w_last;

    assign w_req  = load & ~r_load_q;
    assign w_last = (r_cnt <= c_CNT_W'(1));

    generate
        for (genvar i = 0; i < digit_num; i++) begin : g_digit
            assign w_adj[4*i +: 4] = (r_work[4*i +: 4] >= 4'd5) ?
                                     (r_work[4*i +: 4] + 4'd3) : r_work[4*i +: 4];
        end
    endgenerate

    // Carry out of the top digit is dropped, which yields value mod 10^digit_num.
    assign w_shift = {w_adj, r_bin} << 1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_req)  w_state_next = S_CONV;
            S_CONV:  if (w_last) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_load_q <= 1'b0;
            r_cnt    <= '0;
            r_bin    <= '0;
            r_work   <= '0;
            r_bcd    <= '0;
        end else begin
            r_load_q <= load;
            if (r_state == S_IDLE) begin
                if (w_req) begin
                    r_bin  <= in_data;
                    r_work <= '0;
                    r_cnt  <= c_CNT_W'(data_size);
                end
            end else begin
                r_bin  <= w_shift[data_size-1:0];
                r_work <= w_shift[c_SHW-1:data_size];
                r_cnt  <= r_cnt - c_CNT_W'(1);
                if (w_last) begin
                    r_bcd <= w_shift[c_SHW-1:data_size];
                end
            end
        end
    end

    assign ready = (r_state == S_IDLE);
    assign bcd   = r_bcd;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [digit_num-1:0] c_EN_ZERO = digit_num'(1);

    logic [digit_num-1:0] w_nz;
    logic [digit_num-1:0] w_en_next;
    logic [digit_num-1:0] r_digit_en;

    // w_nz[i] is set when any digit at position i or above is non-zero.
    generate
        for (genvar i = 0; i < digit_num; i++) begin : g_blank
            if (i == digit_num - 1) begin : g_top
                assign w_nz[i] = |w_shift[data_size + 4*i +: 4];
            end else begin : g_mid
                assign w_nz[i] = (|w_shift[data_size + 4*i +: 4]) | w_nz[i+1];
            end
            if (i == 0) begin : g_units
                assign w_en_next[i] = 1'b1;
            end else begin : g_upper
                assign w_en_next[i] = w_nz[i];
            end
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_digit_en <= c_EN_ZERO;
        end else if ((r_state == S_CONV) && w_last) begin
            r_digit_en <= w_en_next;
        end
    end

    assign digit_en = r_digit_en;
`else
    assign digit_en = '1;
`endif

endmodule
`default_nettype wire
